coded_stream_fifo: RTL and testbench

Parametrised first-in/first-out buffer for the coded pixel stream. It is the successor to the write-only coded storage: it has independent write and read pointers, full/empty/almost-full status, an occupancy count, a per-word end-of-frame tag, and sticky overflow/underflow error flags. It sits between the encoder datapath (write side) and the output/readback logic (read side), in the single clk domain.

---
 rtl/coded_stream_fifo_pkg.sv | 13 +
 rtl/coded_stream_fifo_if.sv | 41 ++++
 rtl/coded_stream_fifo_ram.sv | 28 ++
 rtl/coded_stream_fifo.sv | 87 ++++++++
 tb/tb_coded_stream_fifo.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/coded_stream_fifo_pkg.sv
// Shared constants for the image-compression coded stream path.
// Default word/pointer sizes and the stored-entry width helper.
package coded_stream_fifo_pkg;

  localparam int WORD_SIZE_D = 8;
  localparam int ADDR_SIZE_D = 18;
  localparam int ENTRY_SIZE_D = WORD_SIZE_D + 1;

  function automatic int entry_width(input int word);
    return word + 1;
  endfunction

endpackage

// File: rtl/coded_stream_fifo_if.sv
// Write/read handshake bundle of the coded stream FIFO.
// master: encoder/readback side, slave: the FIFO itself.
interface coded_stream_fifo_if
  import coded_stream_fifo_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int ADDR_SIZE = ADDR_SIZE_D
) ();

  logic                 wr_en;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 wr_last;
  logic                 full;
  logic                 almost_full;
  logic                 rd_en;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 rd_last;
  logic                 rd_valid;
  logic                 empty;
  logic [ADDR_SIZE:0]   count;
  logic                 overflow;
  logic                 underflow;
  logic                 clr_err;

  modport master (
    output wr_en, wr_data, wr_last,
    output rd_en, clr_err,
    input  full, almost_full, empty, count,
    input  rd_data, rd_last, rd_valid,
    input  overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, wr_last,
    input  rd_en, clr_err,
    output full, almost_full, empty, count,
    output rd_data, rd_last, rd_valid,
    output overflow, underflow
  );

endinterface

// File: rtl/coded_stream_fifo_ram.sv
// Dual-port storage: sync write port, registered read port.
// rdata resets to 0 and holds its value when re is low.
module fifo_ram #(
  parameter int AW = 18,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/coded_stream_fifo.sv
// Coded pixel stream FIFO with frame tag, status and sticky errors.
// Ports: clk, rst (async active-low), bus (coded_stream_fifo_if.slave).
module coded_stream_fifo
  import coded_stream_fifo_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int ADDR_SIZE = ADDR_SIZE_D,
  parameter int AF_LEVEL  = 2**ADDR_SIZE_D - 4
) (
  input logic               clk,
  input logic               rst,
  coded_stream_fifo_if.slave bus
);

  localparam int EW = entry_width(WORD_SIZE);
  localparam logic [ADDR_SIZE:0] DEPTH =
    {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0] AF =
    AF_LEVEL[ADDR_SIZE:0];

  logic [ADDR_SIZE-1:0] wptr;
  logic [ADDR_SIZE-1:0] rptr;
  logic [ADDR_SIZE:0]   count;
  logic                 rd_valid;
  logic                 overflow;
  logic                 underflow;
  logic                 full;
  logic                 empty;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [EW-1:0]        rdata;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign wr_ok = bus.wr_en && !full;
  assign rd_ok = bus.rd_en && !empty;

  fifo_ram #(
    .AW (ADDR_SIZE),
    .DW (EW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata ({bus.wr_last, bus.wr_data}),
    .re    (rd_ok),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rd_valid  <= rd_ok;
      // a new error in the clearing cycle must survive
      overflow  <= (bus.wr_en && full) ||
                   (overflow && !bus.clr_err);
      underflow <= (bus.rd_en && empty) ||
                   (underflow && !bus.clr_err);
    end
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (count >= AF);
  assign bus.count       = count;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_data     = rdata[WORD_SIZE-1:0];
  assign bus.rd_last     = rdata[WORD_SIZE];
  assign bus.overflow    = overflow;
  assign bus.underflow   = underflow;

endmodule

// File: tb/tb_coded_stream_fifo.sv
// Directed bench for coded_stream_fifo (depth 4, AF_LEVEL 3).
// Hand-computed expectations checked through one task.
module tb_coded_stream_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  coded_stream_fifo_if #(.WORD_SIZE(8), .ADDR_SIZE(2)) bus ();

  coded_stream_fifo #(
    .WORD_SIZE (8),
    .ADDR_SIZE (2),
    .AF_LEVEL  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    bus.wr_last = 1'b0;
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_empty"}, bus.empty, 1);
    chk({tag, "_full"}, bus.full, 0);
    chk({tag, "_af"}, bus.almost_full, 0);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_rdv"}, bus.rd_valid, 0);
    chk({tag, "_ovf"}, bus.overflow, 0);
    chk({tag, "_udf"}, bus.underflow, 0);
  endtask

  logic [7:0] exp_d;

  initial begin
    idle();
    bus.wr_data = 8'h00;
    repeat (2) tick();
    rst_vals("in_rst");
    chk("in_rst_data", bus.rd_data, 0);
    chk("in_rst_last", bus.rd_last, 0);
    rst = 1'b1;
    repeat (3) tick();
    rst_vals("idle");

    // three words, last tag on the third
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h11; tick();
    bus.wr_data = 8'h22; tick();
    chk("af_at2", bus.almost_full, 0);
    bus.wr_data = 8'h33; bus.wr_last = 1'b1; tick();
    idle();
    chk("cnt3", bus.count, 3);
    chk("af_at3", bus.almost_full, 1);
    chk("full_at3", bus.full, 0);
    bus.rd_en = 1'b1;
    tick();
    chk("rd0_v", bus.rd_valid, 1);
    chk("rd0_d", bus.rd_data, 8'h11);
    chk("rd0_l", bus.rd_last, 0);
    tick();
    chk("rd1_d", bus.rd_data, 8'h22);
    chk("rd1_l", bus.rd_last, 0);
    tick();
    chk("rd2_v", bus.rd_valid, 1);
    chk("rd2_d", bus.rd_data, 8'h33);
    chk("rd2_l", bus.rd_last, 1);
    chk("rd2_empty", bus.empty, 1);
    idle();
    tick();
    chk("hold_v", bus.rd_valid, 0);
    chk("hold_d", bus.rd_data, 8'h33);

    // overrun: fifth word dropped
    bus.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = 8'hA0 + 8'(i);
      tick();
      if (i == 3) chk("full_at4", bus.full, 1);
    end
    idle();
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_cnt", bus.count, 4);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = 8'hA0 + 8'(i);
      chk("ovf_rd_v", bus.rd_valid, 1);
      chk("ovf_rd_d", bus.rd_data, exp_d);
    end
    idle();
    chk("ovf_empty", bus.empty, 1);
    bus.clr_err = 1'b1; tick(); idle();
    chk("ovf_clr", bus.overflow, 0);

    // read on empty with same-cycle write
    bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    bus.wr_data = 8'h5C; tick(); idle();
    chk("nft_v", bus.rd_valid, 0);
    chk("nft_udf", bus.underflow, 1);
    chk("nft_cnt", bus.count, 1);
    bus.rd_en = 1'b1; tick(); idle();
    chk("nft_rd_v", bus.rd_valid, 1);
    chk("nft_rd_d", bus.rd_data, 8'h5C);
    bus.clr_err = 1'b1; tick(); idle();
    chk("udf_clr", bus.underflow, 0);

    // steady-state pass-through across pointer wrap
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h60; tick();
    bus.wr_data = 8'h61; tick();
    bus.rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wr_data = 8'h62 + 8'(i);
      tick();
      exp_d = 8'h60 + 8'(i);
      chk("pt_v", bus.rd_valid, 1);
      chk("pt_d", bus.rd_data, exp_d);
      chk("pt_cnt", bus.count, 2);
    end
    bus.rd_en = 1'b0;
    bus.wr_data = 8'h6C; tick();
    bus.wr_data = 8'h6D; tick();
    chk("pt_full", bus.full, 1);
    bus.rd_en = 1'b1;
    bus.wr_data = 8'h6E; tick(); idle();
    chk("fw_v", bus.rd_valid, 1);
    chk("fw_d", bus.rd_data, 8'h6A);
    chk("fw_ovf", bus.overflow, 1);
    chk("fw_cnt", bus.count, 3);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_d = 8'h6B + 8'(i);
      chk("fw_rd_d", bus.rd_data, exp_d);
    end
    idle();
    chk("fw_empty", bus.empty, 1);

    // clear, then async reset mid-stream
    bus.clr_err = 1'b1; tick(); idle();
    chk("clr2_ovf", bus.overflow, 0);
    bus.rd_en = 1'b1; tick(); idle();
    chk("pre_udf", bus.underflow, 1);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h71; tick();
    bus.wr_data = 8'h72; tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1; tick(); idle();
    chk("pre_v", bus.rd_valid, 1);
    chk("pre_d", bus.rd_data, 8'h71);
    #2 rst = 1'b0;
    #1;
    rst_vals("async");
    chk("async_d", bus.rd_data, 0);
    tick();
    rst = 1'b1;
    bus.rd_en = 1'b1; tick(); idle();
    chk("post_v", bus.rd_valid, 0);
    chk("post_udf", bus.underflow, 1);
    chk("post_cnt", bus.count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
